// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ -- universal shift register with frame counter
//
// A WIDTH-bit register that can hold, shift right, shift left or parallel-load
// every rising edge. A saturating counter tracks how many shifts have happened
// since the last load or clear. A registered one-cycle done pulse marks the
// shift that completes a full WIDTH-bit frame.
//
// Parameters
//   WIDTH    register width in bits (>= 2)
//   RST_VAL  value forced into q by clr_n and by sclr
//
// Ports
//   clk    in   1                  rising-edge clock
//   clr_n  in   1                  asynchronous active-low reset
//   en     in   1                  clock enable for mode operations
//   sclr   in   1                  synchronous clear (beats en and mode)
//   mode   in   2                  00 hold, 01 shift right, 10 shift left, 11 load
//   ser_a  in   1                  serial input A
//   ser_b  in   1                  serial input B (serial bit = ser_a & ser_b)
//   d      in   WIDTH              parallel load data
//   q      out  WIDTH              register contents
//   so_r   out  1                  q[0], serial out for right shifts
//   so_l   out  1                  q[WIDTH-1], serial out for left shifts
//   cnt    out  $clog2(WIDTH+1)    shifts since last load/clear, saturating
//   full   out  1                  cnt == WIDTH
//   done   out  1                  one-cycle pulse after the frame-completing shift
//
// There is no handshake on this block: every enabled edge is an operation.
// -----------------------------------------------------------------------------
module shift_reg_univ #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic                         en,
  input  logic                         sclr,
  input  logic [1:0]                   mode,
  input  logic                         ser_a,
  input  logic                         ser_b,
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q,
  output logic                         so_r,
  output logic                         so_l,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         full,
  output logic                         done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_q,    q_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             done_q, done_d;

  logic ser_bit;
  logic shifting;

  assign ser_bit = ser_a & ser_b;

  // Next-state logic. Priority: sclr, then en, then mode. done defaults low so
  // it can only ever be a single-cycle pulse.
  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shifting = 1'b0;

    if (sclr) begin
      q_d   = RST_VAL;
      cnt_d = '0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_d = q_q;
        end
        MODE_RIGHT: begin
          q_d      = {ser_bit, q_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_LEFT: begin
          q_d      = {q_q[WIDTH-2:0], ser_bit};
          shifting = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end

    // Shifts past a full frame still move data but leave the count pinned and
    // never re-fire done; only the WIDTH-1 -> WIDTH transition pulses.
    if (shifting && (cnt_q != CNT_FULL)) begin
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // All outputs derive from registered state only.
  assign q    = q_q;
  assign cnt  = cnt_q;
  assign done = done_q;
  assign so_r = q_q[0];
  assign so_l = q_q[WIDTH-1];
  assign full = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_shift_reg_univ.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_univ -- self-checking bench for shift_reg_univ (WIDTH=8, RST_VAL=0)
//
// Directed scenarios plus a randomized run checked against an arithmetic
// reference model of the register (integer value, shift count, pulse flag).
// -----------------------------------------------------------------------------
module tb_shift_reg_univ;

  localparam int WIDTH = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk;
  logic             clr_n;
  logic             en;
  logic             sclr;
  logic [1:0]       mode;
  logic             ser_a;
  logic             ser_b;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             so_r;
  logic             so_l;
  logic [3:0]       cnt;
  logic             full;
  logic             done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(WIDTH), .RST_VAL(8'h00)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (en),
    .sclr  (sclr),
    .mode  (mode),
    .ser_a (ser_a),
    .ser_b (ser_b),
    .d     (d),
    .q     (q),
    .so_r  (so_r),
    .so_l  (so_l),
    .cnt   (cnt),
    .full  (full),
    .done  (done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------------------
  // Reference model: register as an integer 0..255, count as an integer.
  // ---------------------------------------------------------------------------
  int m_q    = 0;
  int m_cnt  = 0;
  int m_done = 0;

  task automatic model_step(input logic e, input logic sc, input logic [1:0] m,
                            input logic a, input logic b, input logic [7:0] dv);
    int s;
    s = (a && b) ? 1 : 0;
    m_done = 0;
    if (sc) begin
      m_q   = 0;
      m_cnt = 0;
    end else if (e) begin
      if (m == 2'd1 || m == 2'd2) begin
        if (m == 2'd1) m_q = m_q / 2 + s * 128;
        else           m_q = (m_q * 2) % 256 + s;
        if (m_cnt == WIDTH - 1) m_done = 1;
        if (m_cnt < WIDTH) m_cnt = m_cnt + 1;
      end else if (m == 2'd3) begin
        m_q   = int'(dv);
        m_cnt = 0;
      end
    end
  endtask

  // Drive one edge worth of inputs, advance the model, sample #1 after edge.
  task automatic cycle(input logic e, input logic sc, input logic [1:0] m,
                       input logic a, input logic b, input logic [7:0] dv);
    en = e; sclr = sc; mode = m; ser_a = a; ser_b = b; d = dv;
    model_step(e, sc, m, a, b, dv);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    clr_n = 1'b0; en = 1'b1; sclr = 1'b0; mode = 2'b10;
    ser_a = 1'b1; ser_b = 1'b1; d = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
    n_cmp++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if ({so_r, so_l, full} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {so_r, so_l, full});
    end
    en = 1'b0; mode = 2'b00; ser_a = 1'b0; ser_b = 1'b0; d = 8'h00;
    clr_n = 1'b1;
    m_q = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic test_left_pattern;
    logic [7:0] bits;
    bits = 8'b10110010;  // ser_a sequence, first bit applied is bits[7]
    cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 2'b10, bits[7-i], 1'b1, 8'h00);
      n_cmp++; if (cnt !== 4'(i + 1)) begin
        n_fail++; $display("FAIL left_cnt step=%0d got=%0d exp=%0d", i, cnt, i + 1);
      end
      n_cmp++; if (done !== (i == 7)) begin
        n_fail++; $display("FAIL left_done step=%0d got=%b exp=%b", i, done, (i == 7));
      end
    end
    n_cmp++; if (q !== 8'hB2) begin n_fail++; $display("FAIL left_q got=%h exp=b2", q); end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL left_full got=%b exp=1", full); end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL left_done_after got=%b exp=0", done); end
    n_cmp++; if (q !== 8'hB2 || cnt !== 4'd8) begin
      n_fail++; $display("FAIL left_hold got q=%h cnt=%0d exp q=b2 cnt=8", q, cnt);
    end
  endtask

  task automatic test_load_right;
    logic [7:0] exp_q [3];
    logic       exp_so [3];
    exp_q  = '{8'h52, 8'h29, 8'h14};
    exp_so = '{1'b1, 1'b0, 1'b1};
    cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'hA5);
    n_cmp++; if (q !== 8'hA5 || cnt !== 4'd0) begin
      n_fail++; $display("FAIL load_q got q=%h cnt=%0d exp q=a5 cnt=0", q, cnt);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (so_r !== exp_so[i]) begin
        n_fail++; $display("FAIL right_so_r step=%0d got=%b exp=%b", i, so_r, exp_so[i]);
      end
      cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'h00);
      n_cmp++; if (q !== exp_q[i]) begin
        n_fail++; $display("FAIL right_q step=%0d got=%h exp=%h", i, q, exp_q[i]);
      end
    end
    n_cmp++; if (cnt !== 4'd3) begin n_fail++; $display("FAIL right_cnt got=%0d exp=3", cnt); end
  endtask

  task automatic test_enable_sclr;
    cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'h3C);
    cycle(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'h00);  // 0x3C << 1 | 1 = 0x79
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 8'hFF);
      n_cmp++; if (q !== 8'h79 || cnt !== 4'd1 || done !== 1'b0) begin
        n_fail++; $display("FAIL en_hold step=%0d got q=%h cnt=%0d done=%b exp q=79 cnt=1 done=0",
                           i, q, cnt, done);
      end
    end
    cycle(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 8'hFF);
    n_cmp++; if (q !== 8'h00 || cnt !== 4'd0) begin
      n_fail++; $display("FAIL sclr got q=%h cnt=%0d exp q=00 cnt=0", q, cnt);
    end
  endtask

  task automatic test_saturate;
    int pulses;
    pulses = 0;
    cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 8'h00);
      if (done === 1'b1) pulses++;
      n_cmp++; if (cnt !== 4'((i + 1 > 8) ? 8 : i + 1)) begin
        n_fail++; $display("FAIL sat_cnt step=%0d got=%0d exp=%0d", i, cnt, (i + 1 > 8) ? 8 : i + 1);
      end
    end
    n_cmp++; if (q !== 8'h00) begin n_fail++; $display("FAIL sat_q got=%h exp=00", q); end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL sat_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_load_boundary;
    cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 8'h00);
    n_cmp++; if (cnt !== 4'd7) begin n_fail++; $display("FAIL bnd_pre_cnt got=%0d exp=7", cnt); end
    cycle(1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 8'h5A);
    n_cmp++; if (q !== 8'h5A || cnt !== 4'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL bnd_load got q=%h cnt=%0d done=%b exp q=5a cnt=0 done=0", q, cnt, done);
    end
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL bnd_done_after got=%b exp=0", done); end
  endtask

  task automatic test_async_reset;
    cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'h00);
    n_cmp++; if (q !== 8'h07 || cnt !== 4'd3) begin
      n_fail++; $display("FAIL ar_pre got q=%h cnt=%0d exp q=07 cnt=3", q, cnt);
    end
    #2;
    clr_n = 1'b0;
    m_q = 0; m_cnt = 0; m_done = 0;
    #1;  // still before the next rising edge
    n_cmp++; if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate got q=%h cnt=%0d done=%b exp 00/0/0", q, cnt, done);
    end
    en = 1'b1; mode = 2'b10; ser_a = 1'b1; ser_b = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (q !== 8'h00 || cnt !== 4'd0) begin
      n_fail++; $display("FAIL ar_held got q=%h cnt=%0d exp q=00 cnt=0", q, cnt);
    end
    clr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'h00);
      n_cmp++; if (done !== (i == 7)) begin
        n_fail++; $display("FAIL ar_frame_done step=%0d got=%b exp=%b", i, done, (i == 7));
      end
    end
    n_cmp++; if (q !== 8'hFF) begin n_fail++; $display("FAIL ar_frame_q got=%h exp=ff", q); end
  endtask

  task automatic test_random;
    logic       e, sc, a, b;
    logic [1:0] m;
    logic [7:0] dv;
    cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 7) != 0);
      sc = ($urandom_range(0, 39) == 0);
      m  = 2'($urandom_range(0, 3));
      if (m == 2'b11 && $urandom_range(0, 2) != 0) m = 2'($urandom_range(1, 2));
      a  = 1'($urandom_range(0, 1));
      b  = ($urandom_range(0, 3) != 0);
      dv = 8'($urandom_range(0, 255));
      cycle(e, sc, m, a, b, dv);
      n_cmp++;
      if (q !== 8'(m_q) || cnt !== 4'(m_cnt) || done !== (m_done != 0) ||
          so_r !== 1'(m_q % 2) || so_l !== 1'(m_q / 128) || full !== (m_cnt == WIDTH)) begin
        n_fail++;
        $display("FAIL rand step=%0d got q=%h cnt=%0d done=%b so_r=%b so_l=%b full=%b exp q=%h cnt=%0d done=%0d",
                 i, q, cnt, done, so_r, so_l, full, 8'(m_q), m_cnt, m_done);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence + report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_left_pattern();
    test_load_right();
    test_enable_sclr();
    test_saturate();
    test_load_boundary();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
